// File: rtl/ray_frame_buffer_if.sv
// Bundles the write-side pixel stream and the video scan-out signals of the frame buffer.
// The master drives the writes and the video counters; the slave (the frame buffer) returns status and pixels.
interface ray_frame_buffer_if #(
    parameter int PIXEL_WIDTH = 16
);
    logic                   ray_valid_in;
    logic [15:0]            ray_address_in;
    logic [PIXEL_WIDTH-1:0] ray_pixel_in;
    logic                   ray_last_pixel_in;
    logic                   fb_ready_out;
    logic [10:0]            hcount_in;
    logic [9:0]             vcount_in;
    logic [PIXEL_WIDTH-1:0] pixel_out;
    logic                   frame_swap_out;
    logic                   write_bank_out;
    logic                   overflow_out;

    modport master (
        output ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        output hcount_in, vcount_in,
        input  fb_ready_out, pixel_out, frame_swap_out, write_bank_out, overflow_out
    );

    modport slave (
        input  ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        input  hcount_in, vcount_in,
        output fb_ready_out, pixel_out, frame_swap_out, write_bank_out, overflow_out
    );
endinterface

// File: rtl/ray_frame_buffer.sv
// Double-buffered 320x180 RGB565 frame store: one bank is filled by the ray caster while the
// other is scanned out with 4x replication; banks swap on the first blanking line after a full frame.
module ray_frame_buffer #(
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCREEN_WIDTH       = 320,
    parameter int SCREEN_HEIGHT      = 180,
    parameter int PIXEL_WIDTH        = 16
) (
    input logic              pixel_clk_in,
    input logic              rst_in,
    ray_frame_buffer_if.slave bus
);
    localparam int          DEPTH       = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH);
    localparam logic [10:0] H_ACTIVE    = 11'(FULL_SCREEN_WIDTH);
    localparam logic [9:0]  V_ACTIVE    = 10'(FULL_SCREEN_HEIGHT);

    typedef enum logic [0:0] {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   write_bank;
    logic                   swap_pulse;
    logic                   overflow;
    logic                   swap_event;
    logic                   do_swap;
    logic                   write_en;
    logic [15:0]            rd_addr_next;
    logic                   active_next;
    logic [15:0]            rd_addr;
    logic                   active;
    logic                   display_bank;
    logic [PIXEL_WIDTH-1:0] pixel;

    logic [PIXEL_WIDTH-1:0] bank0 [0:DEPTH-1];
    logic [PIXEL_WIDTH-1:0] bank1 [0:DEPTH-1];

    // Write FSM next state, write enable and swap decision
    always_comb begin
        state_next = state;
        do_swap    = 1'b0;
        write_en   = 1'b0;
        swap_event = (bus.hcount_in == 11'd0) && (bus.vcount_in == V_ACTIVE);
        case (state)
            FILL: begin
                write_en = bus.ray_valid_in && (bus.ray_address_in < DEPTH_LIMIT);
                if (bus.ray_valid_in && bus.ray_last_pixel_in) begin
                    state_next = WAIT_SWAP;
                end else begin
                    state_next = FILL;
                end
            end
            WAIT_SWAP: begin
                if (swap_event) begin
                    do_swap    = 1'b1;
                    state_next = FILL;
                end else begin
                    state_next = WAIT_SWAP;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Scan-out address: x/4 + (y/4)*320 with the multiply as (y<<8)+(y<<6)
    always_comb begin
        active_next  = (bus.hcount_in < H_ACTIVE) && (bus.vcount_in < V_ACTIVE);
        rd_addr_next = {7'd0, bus.hcount_in[10:2]}
                     + {bus.vcount_in[9:2], 8'd0}
                     + {2'd0, bus.vcount_in[9:2], 6'd0};
    end

    // FSM state register
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Bank index, swap pulse and sticky overflow flag
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            write_bank <= 1'b0;
            swap_pulse <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            write_bank <= write_bank ^ do_swap;
            swap_pulse <= do_swap;
            overflow   <= overflow | ((state == WAIT_SWAP) && bus.ray_valid_in);
        end
    end

    // Read stage 1: the display bank is captured with the address so a swap cannot tear a read
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_addr      <= 16'd0;
            active       <= 1'b0;
            display_bank <= 1'b1;
        end else begin
            rd_addr      <= active_next ? rd_addr_next : 16'd0;
            active       <= active_next;
            display_bank <= ~write_bank;
        end
    end

    // Bank 0 write port
    always_ff @(posedge pixel_clk_in) begin
        if (write_en && !write_bank) begin
            bank0[bus.ray_address_in] <= bus.ray_pixel_in;
        end
    end

    // Bank 1 write port
    always_ff @(posedge pixel_clk_in) begin
        if (write_en && write_bank) begin
            bank1[bus.ray_address_in] <= bus.ray_pixel_in;
        end
    end

    // Read stage 2: registered BRAM output, blanked outside the active area
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            pixel <= {PIXEL_WIDTH{1'b0}};
        end else if (!active) begin
            pixel <= {PIXEL_WIDTH{1'b0}};
        end else if (display_bank) begin
            pixel <= bank1[rd_addr];
        end else begin
            pixel <= bank0[rd_addr];
        end
    end

    assign bus.fb_ready_out   = (state == FILL);
    assign bus.pixel_out      = pixel;
    assign bus.frame_swap_out = swap_pulse;
    assign bus.write_bank_out = write_bank;
    assign bus.overflow_out   = overflow;
endmodule

// File: tb/tb_ray_frame_buffer.sv
// Directed bench for ray_frame_buffer: a frame-level model of both banks is checked against
// the DUT every cycle, alongside hand-computed expectations at key points of the scenario.
module tb_ray_frame_buffer;
    localparam int DEPTH = 57600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ray_frame_buffer_if #(.PIXEL_WIDTH(16)) bus ();

    ray_frame_buffer dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model: two banks of pixels plus which entries have ever been written
    logic [15:0] mmem   [0:1][0:DEPTH-1];
    bit          mknown [0:1][0:DEPTH-1];
    bit          m_live = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_wb = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_swap = 1'b0;
    logic [15:0] m_s1 = 16'd0;
    logic [15:0] m_out = 16'd0;
    bit          m_s1_known = 1'b0;
    bit          m_out_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        int h, v, idx, addr;
        bit disp, ev;
        h    = int'(bus.hcount_in);
        v    = int'(bus.vcount_in);
        addr = int'(bus.ray_address_in);
        if (rst) begin
            m_live = 1'b1; m_pending = 1'b0; m_wb = 1'b0; m_ovf = 1'b0; m_swap = 1'b0;
            m_out = 16'd0; m_out_known = 1'b1; m_s1_known = 1'b0;
        end else begin
            m_out = m_s1;
            m_out_known = m_s1_known;
            disp = !m_wb;
            if (h < 1280 && v < 720) begin
                idx = h / 4 + (v / 4) * 320;
                m_s1 = mmem[disp][idx];
                m_s1_known = mknown[disp][idx];
            end else begin
                m_s1 = 16'd0;
                m_s1_known = 1'b1;
            end
            ev = (h == 0) && (v == 720);
            m_swap = 1'b0;
            if (m_pending) begin
                if (bus.ray_valid_in) m_ovf = 1'b1;
                if (ev) begin
                    m_swap = 1'b1;
                    m_wb = !m_wb;
                    m_pending = 1'b0;
                end
            end else if (bus.ray_valid_in) begin
                if (addr < DEPTH) begin
                    mmem[m_wb][addr] = bus.ray_pixel_in;
                    mknown[m_wb][addr] = 1'b1;
                end
                if (bus.ray_last_pixel_in) m_pending = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("ready_model", 32'(bus.fb_ready_out), 32'(!m_pending));
            chk("swap_model", 32'(bus.frame_swap_out), 32'(m_swap));
            chk("bank_model", 32'(bus.write_bank_out), 32'(m_wb));
            chk("overflow_model", 32'(bus.overflow_out), 32'(m_ovf));
            if (m_out_known) chk("pixel_model", 32'(bus.pixel_out), 32'(m_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_video(input int h, input int v);
        bus.hcount_in = 11'(h);
        bus.vcount_in = 10'(v);
    endtask

    task automatic idle_video();
        set_video(1300, 0);
    endtask

    task automatic wr(input int addr, input logic [15:0] pix, input bit last);
        bus.ray_valid_in      = 1'b1;
        bus.ray_address_in    = 16'(addr);
        bus.ray_pixel_in      = pix;
        bus.ray_last_pixel_in = last;
        tick();
        bus.ray_valid_in      = 1'b0;
        bus.ray_last_pixel_in = 1'b0;
    endtask

    task automatic swap_line();
        set_video(0, 720);
        tick();
        idle_video();
    endtask

    task automatic read_px(input string name, input int h, input int v, input logic [15:0] exp);
        set_video(h, v);
        tick();
        idle_video();
        tick();
        chk(name, 32'(bus.pixel_out), 32'(exp));
    endtask

    initial begin
        bus.ray_valid_in = 1'b0;
        bus.ray_address_in = 16'd0;
        bus.ray_pixel_in = 16'd0;
        bus.ray_last_pixel_in = 1'b0;
        idle_video();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(bus.fb_ready_out), 32'd1);
        chk("rst_pixel", 32'(bus.pixel_out), 32'd0);
        chk("rst_swap", 32'(bus.frame_swap_out), 32'd0);
        chk("rst_bank", 32'(bus.write_bank_out), 32'd0);
        chk("rst_overflow", 32'(bus.overflow_out), 32'd0);
        rst = 1'b0;
        tick();

        // Full frame into bank 0, pixel value = address
        for (int a = 0; a < DEPTH; a++) begin
            bus.ray_valid_in      = 1'b1;
            bus.ray_address_in    = 16'(a);
            bus.ray_pixel_in      = 16'(a);
            bus.ray_last_pixel_in = (a == DEPTH - 1);
            tick();
        end
        bus.ray_valid_in = 1'b0;
        bus.ray_last_pixel_in = 1'b0;
        chk("ready_after_last", 32'(bus.fb_ready_out), 32'd0);

        swap_line();
        chk("swap1_pulse", 32'(bus.frame_swap_out), 32'd1);
        chk("swap1_bank", 32'(bus.write_bank_out), 32'd1);
        chk("swap1_ready", 32'(bus.fb_ready_out), 32'd1);
        tick();
        chk("swap1_pulse_end", 32'(bus.frame_swap_out), 32'd0);

        read_px("px_4_4", 4, 4, 16'd321);
        read_px("px_8_4", 8, 4, 16'd322);
        read_px("px_row719", 100, 719, 16'd57305);
        read_px("px_h1280", 1280, 0, 16'd0);
        read_px("px_last", 1279, 719, 16'd57599);

        // Partial frame into bank 1 with no last pixel: swap line must be ignored
        for (int i = 0; i < 10; i++) wr(i, 16'hA000 + 16'(i), 1'b0);
        read_px("noswap_before", 0, 0, 16'd0);
        swap_line();
        chk("noswap_pulse", 32'(bus.frame_swap_out), 32'd0);
        chk("noswap_bank", 32'(bus.write_bank_out), 32'd1);
        read_px("noswap_after", 0, 0, 16'd0);

        wr(60000, 16'h1234, 1'b0);
        chk("oob_ready", 32'(bus.fb_ready_out), 32'd1);
        chk("oob_overflow", 32'(bus.overflow_out), 32'd0);

        // Last pixel coincident with the swap line
        bus.ray_valid_in = 1'b1;
        bus.ray_address_in = 16'd10;
        bus.ray_pixel_in = 16'hBEEF;
        bus.ray_last_pixel_in = 1'b1;
        set_video(0, 720);
        tick();
        bus.ray_valid_in = 1'b0;
        bus.ray_last_pixel_in = 1'b0;
        idle_video();
        chk("coinc_ready", 32'(bus.fb_ready_out), 32'd0);
        chk("coinc_swap", 32'(bus.frame_swap_out), 32'd0);
        chk("coinc_bank", 32'(bus.write_bank_out), 32'd1);
        tick();
        swap_line();
        chk("swap2_pulse", 32'(bus.frame_swap_out), 32'd1);
        chk("swap2_bank", 32'(bus.write_bank_out), 32'd0);
        read_px("bank1_px0", 0, 0, 16'hA000);
        read_px("bank1_px1", 4, 0, 16'hA001);
        read_px("bank1_px10", 40, 0, 16'hBEEF);

        // Write in WAIT_SWAP is dropped and latches overflow
        wr(5, 16'h7777, 1'b1);
        chk("wait_ready", 32'(bus.fb_ready_out), 32'd0);
        wr(6, 16'hF800, 1'b0);
        chk("ovf_set", 32'(bus.overflow_out), 32'd1);
        swap_line();
        chk("swap3_bank", 32'(bus.write_bank_out), 32'd1);
        read_px("bank0_px5", 20, 0, 16'h7777);
        read_px("bank0_px6", 24, 0, 16'd6);
        chk("ovf_sticky", 32'(bus.overflow_out), 32'd1);

        // Reset mid-frame
        wr(7, 16'h1111, 1'b0);
        set_video(0, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(bus.fb_ready_out), 32'd1);
        chk("mid_rst_pixel", 32'(bus.pixel_out), 32'd0);
        chk("mid_rst_swap", 32'(bus.frame_swap_out), 32'd0);
        chk("mid_rst_bank", 32'(bus.write_bank_out), 32'd0);
        chk("mid_rst_overflow", 32'(bus.overflow_out), 32'd0);
        rst = 1'b0;
        idle_video();
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
